// File: rtl/la_capture_ctrl.sv
// Capture sequencer for the logic analyser: gates the RLE stage, turns its write strobe into
// SRAM write address/strobe, and walks arm -> pre-trigger -> trigger wait -> post-trigger -> done.
module la_capture_ctrl #(
    parameter int ADDR_W = 19
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              STOP,
    input  logic              RLE_MODE,
    input  logic [ADDR_W-1:0] PRETRIG_CNT,
    input  logic [ADDR_W-1:0] POSTTRIG_CNT,
    input  logic [7:0]        TRIG_MASK,
    input  logic [7:0]        TRIG_VALUE,
    input  logic              TRIG_FORCE,
    input  logic [7:0]        LA_IN_DATA,
    input  logic              LA_SRAM_ADDR_CNT_EN,
    output logic              CLK_EN,
    output logic              RLE_EN,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_WE,
    output logic [ADDR_W-1:0] TRIG_ADDR,
    output logic              WRAPPED,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_TRIG,
        S_POST,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt, wr_ptr_inc;
    logic [ADDR_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [ADDR_W-1:0] pre_len, pre_len_nxt;
    logic [ADDR_W-1:0] post_len, post_len_nxt;
    logic [ADDR_W-1:0] sram_addr_nxt, trig_addr_nxt;
    logic              rle_mode, rle_mode_nxt;
    logic              sram_we_nxt, wrapped_nxt, run_nxt;
    logic              active, accept, hit;

    // Every output is computed from the next state so that it lines up with the state register.
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        cnt_nxt       = cnt;
        pre_len_nxt   = pre_len;
        post_len_nxt  = post_len;
        rle_mode_nxt  = rle_mode;
        sram_addr_nxt = SRAM_ADDR;
        trig_addr_nxt = TRIG_ADDR;
        wrapped_nxt   = WRAPPED;
        sram_we_nxt   = 1'b0;

        wr_ptr_inc = wr_ptr + ADDR_W'(1);
        cnt_inc    = cnt + ADDR_W'(1);
        active     = (state == S_PRE) || (state == S_WAIT_TRIG) || (state == S_POST);
        accept     = LA_SRAM_ADDR_CNT_EN && active;
        hit        = TRIG_FORCE || (((LA_IN_DATA ^ TRIG_VALUE) & TRIG_MASK) == 8'h00);

        if (STOP) begin
            state_nxt = S_IDLE;
        end else begin
            if (accept) begin
                sram_we_nxt   = 1'b1;
                sram_addr_nxt = wr_ptr;
                wr_ptr_nxt    = wr_ptr_inc;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        rle_mode_nxt = RLE_MODE;
                        pre_len_nxt  = PRETRIG_CNT;
                        post_len_nxt = POSTTRIG_CNT;
                        wr_ptr_nxt   = '0;
                        cnt_nxt      = '0;
                        wrapped_nxt  = 1'b0;
                        state_nxt    = (PRETRIG_CNT == '0) ? S_WAIT_TRIG : S_PRE;
                    end
                end
                S_PRE: begin
                    if (accept) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == pre_len) begin
                            cnt_nxt   = '0;
                            state_nxt = S_WAIT_TRIG;
                        end
                    end
                end
                S_WAIT_TRIG: begin
                    if (accept && (wr_ptr == '1)) begin
                        wrapped_nxt = 1'b1;
                    end
                    // wr_ptr_nxt already reflects a same-cycle write, so this is the first post-trigger slot
                    if (hit) begin
                        trig_addr_nxt = wr_ptr_nxt;
                        cnt_nxt       = '0;
                        state_nxt     = (post_len == '0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (accept) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == post_len) begin
                            state_nxt = S_DONE;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        run_nxt = (state_nxt == S_PRE) || (state_nxt == S_WAIT_TRIG) || (state_nxt == S_POST);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            cnt       <= '0;
            pre_len   <= '0;
            post_len  <= '0;
            rle_mode  <= 1'b0;
            CLK_EN    <= 1'b0;
            RLE_EN    <= 1'b0;
            SRAM_ADDR <= '0;
            SRAM_WE   <= 1'b0;
            TRIG_ADDR <= '0;
            WRAPPED   <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            cnt       <= cnt_nxt;
            pre_len   <= pre_len_nxt;
            post_len  <= post_len_nxt;
            rle_mode  <= rle_mode_nxt;
            CLK_EN    <= run_nxt;
            RLE_EN    <= run_nxt && rle_mode_nxt;
            SRAM_ADDR <= sram_addr_nxt;
            SRAM_WE   <= sram_we_nxt;
            TRIG_ADDR <= trig_addr_nxt;
            WRAPPED   <= wrapped_nxt;
            BUSY      <= run_nxt;
            DONE      <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl: a full-width instance plus a 4-bit-address instance for the
// wrap-around case, both driven by the same stimulus.
module tb_la_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, stop, rle_mode, trig_force, strobe;
    logic [18:0] pre19, post19;
    logic [3:0]  pre4, post4;
    logic [7:0]  trig_mask, trig_value, la_in;

    logic        clk_en, rle_en, sram_we, wrapped, busy, done;
    logic [18:0] sram_addr, trig_addr;
    logic        clk_en_s, rle_en_s, sram_we_s, wrapped_s, busy_s, done_s;
    logic [3:0]  sram_addr_s, trig_addr_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    la_capture_ctrl #(.ADDR_W(19)) dut (
        .CLK(clk), .RESET(rst), .START(start), .STOP(stop), .RLE_MODE(rle_mode),
        .PRETRIG_CNT(pre19), .POSTTRIG_CNT(post19), .TRIG_MASK(trig_mask),
        .TRIG_VALUE(trig_value), .TRIG_FORCE(trig_force), .LA_IN_DATA(la_in),
        .LA_SRAM_ADDR_CNT_EN(strobe), .CLK_EN(clk_en), .RLE_EN(rle_en),
        .SRAM_ADDR(sram_addr), .SRAM_WE(sram_we), .TRIG_ADDR(trig_addr),
        .WRAPPED(wrapped), .BUSY(busy), .DONE(done)
    );

    la_capture_ctrl #(.ADDR_W(4)) dut4 (
        .CLK(clk), .RESET(rst), .START(start), .STOP(stop), .RLE_MODE(rle_mode),
        .PRETRIG_CNT(pre4), .POSTTRIG_CNT(post4), .TRIG_MASK(trig_mask),
        .TRIG_VALUE(trig_value), .TRIG_FORCE(trig_force), .LA_IN_DATA(la_in),
        .LA_SRAM_ADDR_CNT_EN(strobe), .CLK_EN(clk_en_s), .RLE_EN(rle_en_s),
        .SRAM_ADDR(sram_addr_s), .SRAM_WE(sram_we_s), .TRIG_ADDR(trig_addr_s),
        .WRAPPED(wrapped_s), .BUSY(busy_s), .DONE(done_s)
    );

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int pre, input int post, input logic rle,
                       input logic [7:0] mask, input logic [7:0] value);
        pre19      = 19'(pre);
        post19     = 19'(post);
        pre4       = 4'(pre);
        post4      = 4'(post);
        rle_mode   = rle;
        trig_mask  = mask;
        trig_value = value;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; stop = 0; rle_mode = 0; trig_force = 0; strobe = 0;
        pre19 = 0; post19 = 0; pre4 = 0; post4 = 0; trig_mask = 0; trig_value = 0; la_in = 0;
        tick();
        tick();
        n_checks++;
        if ({clk_en, rle_en, sram_addr, sram_we, trig_addr, wrapped, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b we=%0b clk_en=%0b, want all 0",
                     busy, done, sram_we, clk_en);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || clk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%0b clk_en=%0b, want 0 0", busy, clk_en);
        end
    endtask

    task automatic test_basic_capture();
        int we_count = 0;
        la_in = 8'h00;
        arm(4, 3, 1'b0, 8'h01, 8'h01);
        n_checks++;
        if (busy !== 1'b1 || clk_en !== 1'b1 || rle_en !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_armed: got busy=%0b clk_en=%0b rle_en=%0b, want 1 1 0",
                     busy, clk_en, rle_en);
        end
        strobe = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 9) la_in = 8'h01;
            tick();
            if (sram_we === 1'b1) we_count++;
            n_checks++;
            if (sram_we !== 1'b1 || sram_addr !== 19'(i)) begin
                n_fail++;
                $display("FAIL basic_write[%0d]: got we=%0b addr=%0d, want we=1 addr=%0d",
                         i, sram_we, sram_addr, i);
            end
            n_checks++;
            if (done !== (i == 12)) begin
                n_fail++;
                $display("FAIL basic_done[%0d]: got %0b, want %0b", i, done, (i == 12));
            end
        end
        n_checks++;
        if (trig_addr !== 19'd10 || busy !== 1'b0 || clk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_trig: got trig_addr=%0d busy=%0b clk_en=%0b, want 10 0 0",
                     trig_addr, busy, clk_en);
        end
        tick();
        n_checks++;
        if (sram_we !== 1'b0 || done !== 1'b1 || we_count != 13) begin
            n_fail++;
            $display("FAIL basic_after_done: got we=%0b done=%0b writes=%0d, want 0 1 13",
                     sram_we, done, we_count);
        end
        strobe = 1'b0;
        la_in  = 8'h00;
    endtask

    task automatic test_stop_start();
        arm(0, 5, 1'b0, 8'hFF, 8'hAA);
        strobe = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || sram_we !== 1'b1 || sram_addr !== 19'd2) begin
            n_fail++;
            $display("FAIL stop_pre: got busy=%0b we=%0b addr=%0d, want 1 1 2",
                     busy, sram_we, sram_addr);
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        n_checks++;
        if (busy !== 0 || clk_en !== 0 || sram_we !== 0 || done !== 0 || trig_addr !== 19'd10) begin
            n_fail++;
            $display("FAIL stop_wait: got busy=%0b clk_en=%0b we=%0b done=%0b trig=%0d, want 0 0 0 0 10",
                     busy, clk_en, sram_we, done, trig_addr);
        end
        start = 1'b0;
        stop  = 1'b0;
        tick();
        n_checks++;
        if (sram_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle_strobe: got we=%0b busy=%0b, want 0 0", sram_we, busy);
        end
        start = 1'b1;
        stop  = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || clk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_wins_idle: got busy=%0b clk_en=%0b, want 0 0", busy, clk_en);
        end
        start  = 1'b0;
        stop   = 1'b0;
        strobe = 1'b0;
    endtask

    task automatic test_wrap();
        la_in = 8'h00;
        arm(2, 3, 1'b0, 8'hFF, 8'hAA);
        strobe = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (sram_we_s !== 1'b1 || sram_addr_s !== 4'(i)) begin
                n_fail++;
                $display("FAIL wrap_write[%0d]: got we=%0b addr=%0d, want we=1 addr=%0d",
                         i, sram_we_s, sram_addr_s, i % 16);
            end
            if (i == 14) begin
                n_checks++;
                if (wrapped_s !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_early: got wrapped=%0b, want 0", wrapped_s);
                end
            end
        end
        n_checks++;
        if (wrapped_s !== 1'b1 || busy_s !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_flag: got wrapped=%0b busy=%0b, want 1 1", wrapped_s, busy_s);
        end
        strobe     = 1'b0;
        trig_force = 1'b1;
        tick();
        trig_force = 1'b0;
        n_checks++;
        if (trig_addr_s !== 4'd4 || sram_we_s !== 1'b0 || busy_s !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_trig: got trig_addr=%0d we=%0b busy=%0b, want 4 0 1",
                     trig_addr_s, sram_we_s, busy_s);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_zero_counts();
        strobe = 1'b0;
        arm(0, 0, 1'b0, 8'h00, 8'h00);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || sram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_first: got busy=%0b done=%0b we=%0b, want 1 0 0", busy, done, sram_we);
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || trig_addr !== 19'd0 || sram_we !== 1'b0 || clk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: got done=%0b busy=%0b trig=%0d we=%0b clk_en=%0b, want 1 0 0 0 0",
                     done, busy, trig_addr, sram_we, clk_en);
        end
    endtask

    task automatic test_rle_spaced();
        arm(2, 2, 1'b1, 8'h00, 8'h00);
        n_checks++;
        if (rle_en !== 1'b1 || clk_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rle_enable: got rle_en=%0b clk_en=%0b, want 1 1", rle_en, clk_en);
        end
        for (int k = 0; k < 4; k++) begin
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            n_checks++;
            if (sram_we !== 1'b1 || sram_addr !== 19'(k)) begin
                n_fail++;
                $display("FAIL rle_write[%0d]: got we=%0b addr=%0d, want 1 %0d", k, sram_we, sram_addr, k);
            end
            n_checks++;
            if (rle_en !== (k < 3)) begin
                n_fail++;
                $display("FAIL rle_en[%0d]: got %0b, want %0b", k, rle_en, (k < 3));
            end
            tick();
            n_checks++;
            if (sram_we !== 1'b0) begin
                n_fail++;
                $display("FAIL rle_gap[%0d]: got we=%0b, want 0", k, sram_we);
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || trig_addr !== 19'd2) begin
            n_fail++;
            $display("FAIL rle_done: got done=%0b trig=%0d, want 1 2", done, trig_addr);
        end
    endtask

    task automatic test_reset_mid_post();
        strobe = 1'b0;
        arm(0, 10, 1'b0, 8'h00, 8'h00);
        strobe = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b1 || trig_addr !== 19'd1 || sram_we !== 1'b1) begin
            n_fail++;
            $display("FAIL midpost_pre: got busy=%0b trig=%0d we=%0b, want 1 1 1", busy, trig_addr, sram_we);
        end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({clk_en, rle_en, sram_addr, sram_we, trig_addr, wrapped, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL midpost_async: got busy=%0b we=%0b addr=%0d trig=%0d, want all 0",
                     busy, sram_we, sram_addr, trig_addr);
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0 || sram_we !== 1'b0 || clk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midpost_idle: got busy=%0b we=%0b clk_en=%0b, want 0 0 0", busy, sram_we, clk_en);
        end
        strobe = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_stop_start();
        test_wrap();
        test_zero_counts();
        test_rle_spaced();
        test_reset_mid_post();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
